// File: rtl/cs_pkg.sv
// Shared constants and state encoding for the CS result buffer.
package cs_pkg;

  localparam int Y_W        = 10;
  localparam int DEPTH_DEF  = 8;
  localparam int WARMUP_DEF = 8;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cs_sync_fifo.sv
// Synchronous FIFO with pre-qualified push/pop. The head entry is visible the cycle after it is written.
// Pointers carry one extra wrap bit to tell full from empty. rd_data reads 0 while empty, so it is never X.
module cs_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/cs_result_buffer.sv
// Discards the first WARMUP filter results after reset, then buffers results for a ready/valid consumer.
// Optional CS_OVERFLOW_CNT_EN builds a saturating drop counter; otherwise drop_count is tied to 0.
module cs_result_buffer
  import cs_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WARMUP = WARMUP_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [Y_W-1:0] y_in,
  input  logic           y_valid,
  output logic [Y_W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           full,
  output logic           overflow,
  output logic [7:0]     drop_count
);

  localparam int            WW         = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [WW-1:0] WU_LAST    = (WARMUP > 0) ? WW'(WARMUP - 1) : '0;
  localparam state_t        STATE_INIT = (WARMUP == 0) ? RUN : WARM;

  state_t        state, state_nxt;
  logic [WW-1:0] wu_cnt, wu_cnt_nxt;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push      = (state == RUN) && y_valid && (!full || pop);
  assign drop      = (state == RUN) && y_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= STATE_INIT;
      wu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wu_cnt <= wu_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wu_cnt_nxt = wu_cnt;
    if (state == WARM && y_valid) begin
      wu_cnt_nxt = wu_cnt + 1'b1;
      if (wu_cnt == WU_LAST) begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef CS_OVERFLOW_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

  cs_sync_fifo #(
    .WIDTH (Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (y_in),
    .pop     (pop),
    .rd_data (out_data),
    .empty   (empty),
    .full    (full)
  );

endmodule

// File: tb/tb_cs_result_buffer.sv
// Directed bench for cs_result_buffer: expected results are queued at issue time and a
// negedge monitor compares every accepted output against the queue head.
module tb_cs_result_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] y_in;
  logic       y_valid;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int sb[$];

`ifdef CS_OVERFLOW_CNT_EN
  localparam int EXP_DROPS = 2;
`else
  localparam int EXP_DROPS = 0;
`endif

  always #5 clk = ~clk;

  cs_result_buffer #(.DEPTH(8), .WARMUP(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .full       (full),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a transfer happens on the next edge when valid && ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", out_data);
      end else begin
        chk("out_data", int'(out_data), sb.pop_front());
      end
    end
  end

  // Drive one sample for one cycle; returns just after the capturing edge.
  task automatic send(input int v, input bit expect_store);
    y_in    = 10'(v);
    y_valid = 1'b1;
    if (expect_store) sb.push_back(v);
    @(posedge clk);
    #1;
    y_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((out_valid || sb.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    chk({name, "_empty_valid"}, int'(out_valid), 0);
    chk({name, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    y_in      = '0;
    y_valid   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Warm-up: eight samples discarded.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(i, 1'b0);
      @(negedge clk);
      chk("warm_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    chk("warm_overflow", int'(overflow), 0);

    // First post-warm-up sample: visible after one edge, popped on the next.
    send(100, 1'b1);
    @(negedge clk);
    chk("first_valid", int'(out_valid), 1);
    chk("first_data", int'(out_data), 100);
    @(posedge clk);
    @(negedge clk);
    chk("first_popped", int'(out_valid), 0);

    // Overfill with consumer stalled: 200..207 stored, 208 and 209 dropped.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(200 + i, i < 8);
    @(negedge clk);
    chk("ovf_full", int'(full), 1);
    chk("ovf_overflow", int'(overflow), 1);
    chk("ovf_drop_count", int'(drop_count), EXP_DROPS);
    chk("ovf_head_stable", int'(out_data), 200);
    @(posedge clk);
    #1;
    drain("drain1");

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(400 + i, 1'b1);
    @(negedge clk);
    chk("pp_full_before", int'(full), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(300, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pp_full_after", int'(full), 1);
    chk("pp_overflow", int'(overflow), 1);
    chk("pp_drop_count", int'(drop_count), EXP_DROPS);
    chk("pp_head", int'(out_data), 401);
    @(posedge clk);
    #1;
    drain("drain2");

    // Reset with five entries buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(500 + i, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_drop_count", int'(drop_count), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(600 + i, 1'b0);
      @(negedge clk);
      chk("rewarm_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
    end
    chk("rewarm_overflow", int'(overflow), 0);
    send(700, 1'b1);
    drain("drain3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
